bresenham_line: RTL and testbench
=================================

// Module: bresenham_line
// PURPOSE
//  Rasterises one laser-scan ray from the robot cell (x0,y0) to the hit cell (x1,y1) using integer Bresenham.
//  Sits between control_unit (bresenham_start / bresenham_busy) and the occupancy grid update stage.
//  Emits one grid cell per accepted handshake; the final cell is flagged as the occupied endpoint.
//  All earlier cells are free-space cells.
// PARAMETERS
//  COORD_W      11   signed coordinate width (two's complement) for inputs, outputs and internal x/y
//  GRID_WIDTH   640  grid columns; used only when BRESENHAM_CLIP_EN is defined
//  GRID_HEIGHT  480  grid rows; used only when BRESENHAM_CLIP_EN is defined
// PORTS
//  clock        in   1        single clock; all logic on posedge
//  reset        in   1        synchronous, active-high
//  start        in   1        one-cycle request; sampled only in IDLE
//  x0, y0       in   COORD_W  ray origin (robot position), signed
//  x1, y1       in   COORD_W  ray end (scan hit), signed
//  busy         out  1        high in SETUP and STEP
//  done         out  1        one-cycle pulse after the last cell is handled
//  point_x      out  COORD_W  current cell x
//  point_y      out  COORD_W  current cell y
//  point_last   out  1        qualifies point_valid: cell is the endpoint (occupied)
//  point_valid  out  1        cell available to the consumer
//  point_ready  in   1        consumer accepts; transfer = point_valid && point_ready
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, point_valid and point_last = 0; point_x and point_y = 0.
//   Reset has priority in every state and aborts a line in progress with no done pulse.
//  Registered state machine: IDLE -> SETUP -> STEP -> DONE -> IDLE.
//  IDLE: start=1 latches x0, y0, x1 and y1, then moves to SETUP. start outside IDLE is ignored (no queueing).
//  SETUP: computes dx=|x1-x0|, dy=-|y1-y0|, sx=sign(x1-x0), sy=sign(y1-y0) (+1 when equal) and err=dx+dy.
//   Loads x=x0, y=y0. Duration is 1 cycle.
//  STEP: point_valid=1 and point_x/point_y=(x,y); point_last=1 when (x,y)==(x1,y1).
//   While valid && !ready, every point_* output holds stable.
//   On transfer of a non-last cell, with e2=2*err:
//    if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy.
//    Both updates use the same e2 and apply in the same cycle.
//   On transfer of the last cell, go to DONE.
//  DONE: done=1 and busy=0 for 1 cycle, then IDLE.
//  Arithmetic: dx, dy and err are signed COORD_W+2 wide, so there is no overflow for any legal input.
//  Latency: start sampled at cycle N -> busy=1 at N+1 -> first point_valid at N+2.
//   With point_ready tied high, one cell per cycle and max(dx,-dy)+1 cells.
//   done pulses one cycle after the last transfer.
//  Degenerate ray (x0,y0)==(x1,y1): exactly one cell, with point_last=1.
//  start and reset both high: reset wins.
// CONFIGURATION
//  BRESENHAM_CLIP_EN defined:
//   Cells with x<0, x>=GRID_WIDTH, y<0 or y>=GRID_HEIGHT are not presented. point_valid=0 for them.
//   Stepping past them continues at 1 cell/cycle without waiting for point_ready.
//   If the endpoint is outside the grid, no point_last is emitted; done still pulses.
//  BRESENHAM_CLIP_EN undefined: every cell is presented and the consumer is responsible for range checks.
// TESTING
//  T1 (0,0)->(5,2), ready=1:
//     cells (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); last only on (5,2).
//     busy high for 7 cycles; done 1 cycle after (5,2).
//  T2 (7,7)->(7,7): single cell (7,7) with point_last=1; first valid at N+2, done at N+3.
//  T3 T1 with ready low for 3 cycles while (1,0) is valid:
//     (1,0) and point_last held stable; the sequence resumes unchanged with no cell skipped or duplicated.
//  T4 (0,0)->(-1,-3), clip off: cells (0,0),(0,-1),(-1,-2),(-1,-3)last.
//     Same ray with BRESENHAM_CLIP_EN: only (0,0), no point_last, done still pulses.
//  T5 start re-pulsed while busy during T1: ignored and output identical to T1.
//     Reset asserted at the 3rd cell: next cycle busy=0, point_valid=0, no done.
//     A fresh start then behaves as in T1.

Source files
------------

// File: rtl/bresenham_line_if.sv
// ---------------------------------------------------------------------------
// bresenham_line_if
// Purpose: bundles the request side (start, ray endpoints, busy, done) and the
//          cell stream (point_*) of the Bresenham ray rasteriser.
// Parameters:
//   COORD_W      signed coordinate width
// Modports:
//   master       requester/consumer view: drives start, x0..y1, point_ready
//   slave        rasteriser view: drives busy, done, point_x/y/last/valid
// ---------------------------------------------------------------------------
interface bresenham_line_if #(
    parameter int COORD_W = 11
);
    logic                      start;
    logic signed [COORD_W-1:0] x0;
    logic signed [COORD_W-1:0] y0;
    logic signed [COORD_W-1:0] x1;
    logic signed [COORD_W-1:0] y1;
    logic                      busy;
    logic                      done;
    logic signed [COORD_W-1:0] point_x;
    logic signed [COORD_W-1:0] point_y;
    logic                      point_last;
    logic                      point_valid;
    logic                      point_ready;

    modport master (
        output start, x0, y0, x1, y1, point_ready,
        input  busy, done, point_x, point_y, point_last, point_valid
    );

    modport slave (
        input  start, x0, y0, x1, y1, point_ready,
        output busy, done, point_x, point_y, point_last, point_valid
    );
endinterface

// File: rtl/bresenham_line.sv
// ---------------------------------------------------------------------------
// bresenham_line
// Purpose: rasterises one laser-scan ray from the robot cell (x0,y0) to the
//          hit cell (x1,y1) with integer Bresenham. One cell is emitted per
//          accepted valid/ready transfer; the final cell carries point_last
//          (occupied endpoint), all earlier cells are free space.
// Parameters:
//   COORD_W      signed coordinate width (default 11)
//   GRID_WIDTH   grid columns (only used with BRESENHAM_CLIP_EN)
//   GRID_HEIGHT  grid rows    (only used with BRESENHAM_CLIP_EN)
// Ports:
//   clock        single clock, posedge
//   reset        synchronous, active-high
//   bus          bresenham_line_if.slave: start/x0/y0/x1/y1 in, busy/done out,
//                point_x/point_y/point_last/point_valid out, point_ready in
// Configuration:
//   BRESENHAM_CLIP_EN  when defined, cells outside the grid are stepped over
//                      at one per cycle without being presented.
// ---------------------------------------------------------------------------
module bresenham_line #(
    parameter int COORD_W     = 11,
    parameter int GRID_WIDTH  = 640,
    parameter int GRID_HEIGHT = 480
) (
    input  logic            clock,
    input  logic            reset,
    bresenham_line_if.slave bus
);
    // two guard bits keep dx, dy and err free of overflow for any legal ray
    localparam int EW = COORD_W + 2;
    localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

    typedef enum logic [1:0] {IDLE, SETUP, STEP, DONE} state_t;

    state_t state;
    state_t state_next;

    logic signed [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;
    logic signed [COORD_W-1:0] x, y;
    logic signed [EW-1:0]      dx, dy, err;
    logic                      sx_neg, sy_neg;

    logic signed [EW-1:0]      diff_x, diff_y, abs_x, abs_y;
    logic signed [EW:0]        e2, dx_ext, dy_ext;
    logic signed [EW-1:0]      err_step;
    logic                      step_x, step_y;
    logic                      at_end, in_grid, advance;
    logic                      busy_w, done_w, valid_w, last_w;

    assign diff_x = $signed({{2{x1_r[COORD_W-1]}}, x1_r}) - $signed({{2{x0_r[COORD_W-1]}}, x0_r});
    assign diff_y = $signed({{2{y1_r[COORD_W-1]}}, y1_r}) - $signed({{2{y0_r[COORD_W-1]}}, y0_r});
    assign abs_x  = diff_x[EW-1] ? -diff_x : diff_x;
    assign abs_y  = diff_y[EW-1] ? -diff_y : diff_y;

    // e2 = 2*err needs one extra bit; dx/dy are widened to match for compares
    assign e2     = $signed({err, 1'b0});
    assign dx_ext = $signed({dx[EW-1], dx});
    assign dy_ext = $signed({dy[EW-1], dy});
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);

    // both error corrections use the same e2 and land in the same cycle
    always_comb begin
        err_step = err;
        if (step_x) err_step = err_step + dy;
        if (step_y) err_step = err_step + dx;
    end

    assign at_end = (x == x1_r) && (y == y1_r);

`ifdef BRESENHAM_CLIP_EN
    localparam logic signed [EW-1:0] GRID_W_L = EW'(GRID_WIDTH);
    localparam logic signed [EW-1:0] GRID_H_L = EW'(GRID_HEIGHT);
    logic signed [EW-1:0] x_ext, y_ext;
    assign x_ext   = $signed({{2{x[COORD_W-1]}}, x});
    assign y_ext   = $signed({{2{y[COORD_W-1]}}, y});
    assign in_grid = !x[COORD_W-1] && !y[COORD_W-1] && (x_ext < GRID_W_L) && (y_ext < GRID_H_L);
`else
    assign in_grid = 1'b1;
`endif

    // off-grid cells are never presented, so they advance without a handshake
    assign advance = (state == STEP) && (in_grid ? bus.point_ready : 1'b1);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_w     = 1'b0;
        done_w     = 1'b0;
        valid_w    = 1'b0;
        last_w     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = SETUP;
            end
            SETUP: begin
                busy_w     = 1'b1;
                state_next = STEP;
            end
            STEP: begin
                busy_w  = 1'b1;
                valid_w = in_grid;
                last_w  = in_grid && at_end;
                if (advance && at_end) state_next = DONE;
            end
            DONE: begin
                done_w     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x0_r   <= '0;
            y0_r   <= '0;
            x1_r   <= '0;
            y1_r   <= '0;
            x      <= '0;
            y      <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x0_r <= bus.x0;
                        y0_r <= bus.y0;
                        x1_r <= bus.x1;
                        y1_r <= bus.y1;
                    end
                end
                SETUP: begin
                    dx     <= abs_x;
                    dy     <= -abs_y;
                    err    <= abs_x - abs_y;
                    sx_neg <= diff_x[EW-1];
                    sy_neg <= diff_y[EW-1];
                    x      <= x0_r;
                    y      <= y0_r;
                end
                STEP: begin
                    if (advance && !at_end) begin
                        err <= err_step;
                        if (step_x) x <= sx_neg ? x - ONE : x + ONE;
                        if (step_y) y <= sy_neg ? y - ONE : y + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_w;
    assign bus.done        = done_w;
    assign bus.point_valid = valid_w;
    assign bus.point_last  = last_w;
    assign bus.point_x     = x;
    assign bus.point_y     = y;

endmodule

// File: tb/tb_bresenham_line.sv
// ---------------------------------------------------------------------------
// tb_bresenham_line
// Purpose: self-checking bench for bresenham_line using directed rays with
//          hand-computed cell lists, back-pressure, ignored re-start and
//          mid-line reset.
// Configuration: BRESENHAM_CLIP_EN selects the clipped expectations for the
//          ray that leaves the grid.
// ---------------------------------------------------------------------------
module tb_bresenham_line;
    localparam int CW = 11;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    int   expX[$];
    int   expY[$];
    int   expTotal;
    bit   expLastFlag;

    bresenham_line_if #(.COORD_W(CW)) bus ();

    bresenham_line #(
        .COORD_W    (CW),
        .GRID_WIDTH (640),
        .GRID_HEIGHT(480)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearExpected(input int total, input bit lastFlag);
        expX.delete();
        expY.delete();
        expTotal    = total;
        expLastFlag = lastFlag;
    endtask

    task automatic addCell(input int cx, input int cy);
        expX.push_back(cx);
        expY.push_back(cy);
    endtask

    // entered on a negedge; leaves on the negedge after start was sampled
    task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1);
        bus.x0    = CW'(ax0);
        bus.y0    = CW'(ay0);
        bus.x1    = CW'(ax1);
        bus.y1    = CW'(ay1);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic checkCell(input string name, input int idx);
        int lastExp;
        if (idx >= expX.size()) begin
            checkOutput($sformatf("%s_extra_cell", name), idx, expX.size() - 1);
        end else begin
            lastExp = (expLastFlag && idx == expX.size() - 1) ? 1 : 0;
            checkOutput($sformatf("%s_x%0d", name, idx), int'($signed(bus.point_x)), expX[idx]);
            checkOutput($sformatf("%s_y%0d", name, idx), int'($signed(bus.point_y)), expY[idx]);
            checkOutput($sformatf("%s_last%0d", name, idx), int'(bus.point_last), lastExp);
        end
    endtask

    // cycle numbers are relative to the posedge that samples start (cycle 0)
    task automatic runLine(input string name, input int ax0, input int ay0, input int ax1,
                           input int ay1, input int stallIdx, input int restartIdx,
                           input int resetIdx);
        int  idx;
        int  busyCycles;
        int  stalls;
        int  doneCyc;
        int  sawDone;
        bit  aborted;
        idx        = 0;
        stalls     = 0;
        doneCyc    = -1;
        aborted    = 1'b0;
        bus.point_ready = 1'b1;
        applyStimulus(ax0, ay0, ax1, ay1);
        checkOutput({name, "_busy_setup"}, int'(bus.busy), 1);
        checkOutput({name, "_valid_setup"}, int'(bus.point_valid), 0);
        busyCycles = int'(bus.busy);
        for (int cyc = 2; cyc < 60 && doneCyc < 0 && !aborted; cyc++) begin
            @(negedge clock);
            bus.start       = 1'b0;
            bus.point_ready = 1'b1;
            if (bus.busy) busyCycles++;
            if (bus.done) doneCyc = cyc;
            if (cyc == 2) checkOutput({name, "_first_valid"}, int'(bus.point_valid), 1);
            if (bus.point_valid) begin
                if (idx == resetIdx) begin
                    reset = 1'b1;
                    @(negedge clock);
                    checkOutput({name, "_rst_busy"}, int'(bus.busy), 0);
                    checkOutput({name, "_rst_valid"}, int'(bus.point_valid), 0);
                    checkOutput({name, "_rst_done"}, int'(bus.done), 0);
                    checkOutput({name, "_rst_x"}, int'($signed(bus.point_x)), 0);
                    reset   = 1'b0;
                    sawDone = 0;
                    repeat (4) begin
                        @(negedge clock);
                        sawDone = sawDone | int'(bus.done);
                    end
                    checkOutput({name, "_rst_no_done"}, sawDone, 0);
                    aborted = 1'b1;
                end else if (idx == stallIdx && stalls < 3) begin
                    bus.point_ready = 1'b0;
                    checkCell({name, "_stall"}, idx);
                    stalls++;
                end else begin
                    if (idx == restartIdx) begin
                        bus.start = 1'b1;
                        bus.x0    = CW'(100);
                        bus.y0    = CW'(-7);
                        bus.x1    = CW'(-50);
                        bus.y1    = CW'(33);
                    end
                    checkCell(name, idx);
                    idx++;
                end
            end
        end
        bus.start       = 1'b0;
        bus.point_ready = 1'b1;
        if (!aborted) begin
            checkOutput({name, "_cell_count"}, idx, expX.size());
            checkOutput({name, "_done_cycle"}, doneCyc, 2 + expTotal + stalls);
            checkOutput({name, "_busy_cycles"}, busyCycles, 1 + expTotal + stalls);
            @(negedge clock);
            checkOutput({name, "_done_pulse_len"}, int'(bus.done), 0);
            checkOutput({name, "_idle_busy"}, int'(bus.busy), 0);
        end
    endtask

    task automatic loadT1();
        clearExpected(6, 1'b1);
        addCell(0, 0); addCell(1, 0); addCell(2, 1);
        addCell(3, 1); addCell(4, 2); addCell(5, 2);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.x0          = '0;
        bus.y0          = '0;
        bus.x1          = '0;
        bus.y1          = '0;
        bus.point_ready = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_valid", int'(bus.point_valid), 0);
        checkOutput("reset_last", int'(bus.point_last), 0);
        checkOutput("reset_x", int'($signed(bus.point_x)), 0);
        checkOutput("reset_y", int'($signed(bus.point_y)), 0);

        // start and reset together: reset wins, nothing starts
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        checkOutput("start_with_reset_busy", int'(bus.busy), 0);

        loadT1();
        runLine("t1", 0, 0, 5, 2, -1, -1, -1);

        clearExpected(1, 1'b1);
        addCell(7, 7);
        runLine("t2", 7, 7, 7, 7, -1, -1, -1);

        loadT1();
        runLine("t3", 0, 0, 5, 2, 1, -1, -1);

`ifdef BRESENHAM_CLIP_EN
        clearExpected(4, 1'b0);
        addCell(0, 0);
`else
        clearExpected(4, 1'b1);
        addCell(0, 0); addCell(0, -1); addCell(-1, -2); addCell(-1, -3);
`endif
        runLine("t4", 0, 0, -1, -3, -1, -1, -1);

        clearExpected(4, 1'b1);
        addCell(3, 5); addCell(2, 5); addCell(1, 5); addCell(0, 5);
        runLine("hneg", 3, 5, 0, 5, -1, -1, -1);

        loadT1();
        runLine("t5_restart", 0, 0, 5, 2, -1, 3, -1);

        loadT1();
        runLine("t5_reset", 0, 0, 5, 2, -1, -1, 2);

        loadT1();
        runLine("t5_fresh", 0, 0, 5, 2, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
